// File: rtl/i2c_slave_regfile_if.sv
// I2C bus bundle between an I2C master and the register-file target.
// The master drives SCL and the resolved SDA wire; the target answers
// through an open-drain enable (1 = pull SDA low).
interface i2c_slave_regfile_if;
    logic i2c_scl;
    logic i2c_sda;
    logic sda_oe;

    modport master (
        output i2c_scl,
        output i2c_sda,
        input  sda_oe
    );

    modport slave (
        input  i2c_scl,
        input  i2c_sda,
        output sda_oe
    );
endinterface

// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile: I2C target with an internal byte register file.
// Matches a 7-bit device address, takes a register pointer byte, then
// stores the following data bytes with an auto-incrementing, wrapping pointer.
// Optional feature macro: I2C_READ_EN (adds master-read support, RD_DATA state).
// Without it the block is write-only and read addressing is NACKed.
module i2c_slave_regfile #(
    parameter logic [6:0] DEV_ADDR  = 7'h0A,
    parameter int         NUM_REG   = 32,
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic               clk_sda,
    input  logic               rst_n,
    i2c_slave_regfile_if.slave bus,
    output logic               wr_en,
    output logic [7:0]         wr_addr,
    output logic [7:0]         wr_data,
    output logic               busy,
    output logic               stop_det,
    input  logic [7:0]         dbg_addr,
    output logic [7:0]         dbg_data
);
    localparam int         PTR_W     = (NUM_REG > 1) ? $clog2(NUM_REG) : 1;
    localparam logic [8:0] NUM_REG_9 = 9'(NUM_REG);
    localparam logic [7:0] LAST_REG  = 8'(NUM_REG - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEV_ADDR,
        S_REG_ADDR,
        S_WR_DATA,
        S_IGNORE
`ifdef I2C_READ_EN
        ,
        S_RD_DATA
`endif
    } state_t;

    // PH_BITS: shifting bits; PH_DONE: byte complete, waiting for the SCL
    // fall that opens the ACK slot; PH_ACK: inside the ACK slot.
    typedef enum logic [1:0] {
        PH_BITS,
        PH_DONE,
        PH_ACK
    } phase_t;

    state_t     state;
    state_t     next_state;
    phase_t     phase;
    logic [2:0] bit_cnt;
    logic [7:0] shift_reg;
    logic [7:0] pointer;
    logic       byte_rdy;
    logic       ack_ok;
    logic       sda_oe_r;
    logic [7:0] regs [NUM_REG];
`ifdef I2C_READ_EN
    logic [7:0] tx_byte;
`endif

    logic scl_s1, scl_s2, scl_d;
    logic sda_s1, sda_s2, sda_d;
    logic scl_rise, scl_fall, start_evt, stop_evt;
    logic [7:0] ptr_inc;

    assign bus.sda_oe = sda_oe_r;

    // Two-stage synchronizers plus one history stage for edge detection; idle bus is high.
    always_ff @(posedge clk_sda or negedge rst_n) begin
        if (!rst_n) begin
            {scl_s1, scl_s2, scl_d} <= 3'b111;
            {sda_s1, sda_s2, sda_d} <= 3'b111;
        end else begin
            scl_s1 <= bus.i2c_scl;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
            sda_s1 <= bus.i2c_sda;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;
        end
    end

    assign scl_rise  = scl_s2 & ~scl_d;
    assign scl_fall  = ~scl_s2 & scl_d;
    assign start_evt = scl_s2 & scl_d & sda_d & ~sda_s2;
    assign stop_evt  = scl_s2 & scl_d & ~sda_d & sda_s2;
    assign ptr_inc   = (pointer == LAST_REG) ? 8'h00 : pointer + 8'd1;
    assign dbg_data  = ({1'b0, dbg_addr} < NUM_REG_9) ? regs[dbg_addr[PTR_W-1:0]] : 8'h00;

    // Protocol FSM: STOP beats START beats a completed byte beats SCL edges.
    always_ff @(posedge clk_sda or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            next_state <= S_IDLE;
            phase      <= PH_BITS;
            bit_cnt    <= 3'd7;
            shift_reg  <= 8'h00;
            pointer    <= 8'h00;
            byte_rdy   <= 1'b0;
            ack_ok     <= 1'b0;
            sda_oe_r   <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= 8'h00;
            wr_data    <= 8'h00;
            busy       <= 1'b0;
            stop_det   <= 1'b0;
`ifdef I2C_READ_EN
            tx_byte    <= 8'h00;
`endif
            for (int i = 0; i < NUM_REG; i++) begin
                regs[i] <= RESET_VAL;
            end
        end else begin
            wr_en    <= 1'b0;
            stop_det <= 1'b0;
            if (stop_evt) begin
                state    <= S_IDLE;
                phase    <= PH_BITS;
                bit_cnt  <= 3'd7;
                byte_rdy <= 1'b0;
                sda_oe_r <= 1'b0;
                busy     <= 1'b0;
                stop_det <= 1'b1;
            end else if (start_evt) begin
                state    <= S_DEV_ADDR;
                phase    <= PH_BITS;
                bit_cnt  <= 3'd7;
                byte_rdy <= 1'b0;
                sda_oe_r <= 1'b0;
                busy     <= 1'b1;
            end else if (byte_rdy) begin
                byte_rdy <= 1'b0;
                case (state)
                    S_DEV_ADDR: begin
                        if (shift_reg == {DEV_ADDR, 1'b0}) begin
                            ack_ok     <= 1'b1;
                            next_state <= S_REG_ADDR;
`ifdef I2C_READ_EN
                        end else if (shift_reg == {DEV_ADDR, 1'b1}) begin
                            ack_ok     <= 1'b1;
                            next_state <= S_RD_DATA;
`endif
                        end else begin
                            ack_ok     <= 1'b0;
                            next_state <= S_IGNORE;
                        end
                    end
                    S_REG_ADDR: begin
                        if ({1'b0, shift_reg} < NUM_REG_9) begin
                            pointer    <= shift_reg;
                            ack_ok     <= 1'b1;
                            next_state <= S_WR_DATA;
                        end else begin
                            ack_ok     <= 1'b0;
                            next_state <= S_IGNORE;
                        end
                    end
                    S_WR_DATA: begin
                        regs[pointer[PTR_W-1:0]] <= shift_reg;
                        wr_en      <= 1'b1;
                        wr_addr    <= pointer;
                        wr_data    <= shift_reg;
                        pointer    <= ptr_inc;
                        ack_ok     <= 1'b1;
                        next_state <= S_WR_DATA;
                    end
                    default: begin
                        ack_ok     <= 1'b0;
                        next_state <= S_IGNORE;
                    end
                endcase
            end else if (scl_rise) begin
                case (phase)
                    PH_BITS: begin
                        if (state == S_DEV_ADDR || state == S_REG_ADDR || state == S_WR_DATA) begin
                            shift_reg <= {shift_reg[6:0], sda_s2};
                            if (bit_cnt == 3'd0) begin
                                byte_rdy <= 1'b1;
                                phase    <= PH_DONE;
                            end else begin
                                bit_cnt <= bit_cnt - 3'd1;
                            end
`ifdef I2C_READ_EN
                        end else if (state == S_RD_DATA) begin
                            if (bit_cnt == 3'd0) begin
                                phase <= PH_DONE;
                            end else begin
                                bit_cnt <= bit_cnt - 3'd1;
                            end
`endif
                        end
                    end
`ifdef I2C_READ_EN
                    PH_ACK: begin
                        if (state == S_RD_DATA) begin
                            ack_ok <= ~sda_s2;
                        end
                    end
`endif
                    default: begin
                    end
                endcase
            end else if (scl_fall) begin
                case (phase)
`ifdef I2C_READ_EN
                    PH_BITS: begin
                        if (state == S_RD_DATA) begin
                            sda_oe_r <= ~tx_byte[bit_cnt];
                        end
                    end
`endif
                    PH_DONE: begin
`ifdef I2C_READ_EN
                        if (state == S_RD_DATA) begin
                            sda_oe_r <= 1'b0;
                        end else
`endif
                        begin
                            sda_oe_r <= ack_ok;
                        end
                        phase <= PH_ACK;
                    end
                    PH_ACK: begin
                        bit_cnt <= 3'd7;
                        phase   <= PH_BITS;
`ifdef I2C_READ_EN
                        if (state == S_RD_DATA) begin
                            if (ack_ok) begin
                                pointer  <= ptr_inc;
                                tx_byte  <= regs[ptr_inc[PTR_W-1:0]];
                                sda_oe_r <= ~regs[ptr_inc[PTR_W-1:0]][7];
                            end else begin
                                state    <= S_IGNORE;
                                sda_oe_r <= 1'b0;
                            end
                        end else if (next_state == S_RD_DATA) begin
                            state    <= S_RD_DATA;
                            tx_byte  <= regs[pointer[PTR_W-1:0]];
                            sda_oe_r <= ~regs[pointer[PTR_W-1:0]][7];
                        end else
`endif
                        begin
                            sda_oe_r <= 1'b0;
                            state    <= next_state;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Self-checking bench for i2c_slave_regfile: a bit-banged I2C master drives
// the bus while a queue/array reference model predicts ACKs, writes and the
// register file contents. Read checks are enabled with I2C_READ_EN.
module tb_i2c_slave_regfile;
    localparam int         NUM_REG   = 32;
    localparam logic [7:0] RESET_VAL = 8'h00;
    localparam int         Q         = 60;

    logic       clk_sda = 1'b0;
    logic       rst_n;
    logic       master_scl = 1'b1;
    logic       master_sda = 1'b1;
    logic       wr_en, busy, stop_det;
    logic [7:0] wr_addr, wr_data, dbg_addr, dbg_data;

    i2c_slave_regfile_if bus();

    assign bus.i2c_scl = master_scl;
    assign bus.i2c_sda = master_sda & ~bus.sda_oe;

    i2c_slave_regfile #(
        .DEV_ADDR (7'h0A),
        .NUM_REG  (NUM_REG),
        .RESET_VAL(RESET_VAL)
    ) dut (
        .clk_sda (clk_sda),
        .rst_n   (rst_n),
        .bus     (bus),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy),
        .stop_det(stop_det),
        .dbg_addr(dbg_addr),
        .dbg_data(dbg_data)
    );

    always #5 clk_sda = ~clk_sda;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  model_regs [NUM_REG];
    int          model_ptr;
    logic [7:0]  tx_q[$];
    bit          exp_ack[$];
    logic [15:0] exp_wr[$];
    logic [15:0] obs_wr[$];
    int          stop_count = 0;
    int          last_ack_count;

    // Passive monitor: log every write pulse and STOP pulse.
    always @(negedge clk_sda) begin
        if (wr_en) obs_wr.push_back({wr_addr, wr_data});
        if (stop_det) stop_count++;
    end

    task automatic bus_start();
        master_sda = 1'b1; #(Q);
        master_scl = 1'b1; #(Q);
        master_sda = 1'b0; #(Q);
        master_scl = 1'b0; #(Q);
    endtask

    task automatic bus_stop();
        master_sda = 1'b0; #(Q);
        master_scl = 1'b1; #(Q);
        master_sda = 1'b1; #(Q);
        #(Q);
    endtask

    task automatic send_bit(input logic b);
        master_sda = b; #(Q);
        master_scl = 1'b1; #(Q);
        #(Q);
        master_scl = 1'b0; #(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        master_sda = 1'b1; #(Q);
        master_scl = 1'b1; #(Q);
        acked = ~bus.i2c_sda; #(Q);
        master_scl = 1'b0; #(Q);
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] v);
        v = 8'h00;
        for (int i = 0; i < 8; i++) begin
            master_sda = 1'b1; #(Q);
            master_scl = 1'b1; #(Q);
            v = {v[6:0], bus.i2c_sda}; #(Q);
            master_scl = 1'b0; #(Q);
        end
        send_bit(~mack);
    endtask

    // Reference model: address byte, register byte, then data bytes with wrap.
    task automatic model_txn();
        bit addr_ok, reg_ok;
        exp_ack.delete();
        exp_wr.delete();
        addr_ok = (tx_q[0] == 8'h14);
        reg_ok  = 1'b0;
        for (int k = 0; k < tx_q.size(); k++) begin
            if (k == 0) begin
                exp_ack.push_back(addr_ok);
            end else if (k == 1) begin
                reg_ok = addr_ok && (int'(tx_q[1]) < NUM_REG);
                exp_ack.push_back(reg_ok);
                if (reg_ok) model_ptr = int'(tx_q[1]);
            end else begin
                exp_ack.push_back(reg_ok);
                if (reg_ok) begin
                    model_regs[model_ptr] = tx_q[k];
                    exp_wr.push_back({8'(model_ptr), tx_q[k]});
                    model_ptr = (model_ptr + 1) % NUM_REG;
                end
            end
        end
    endtask

    // START (or repeated START) followed by tx_q; the caller decides on STOP.
    task automatic run_txn(input string name);
        int   base;
        logic acked;
        base = obs_wr.size();
        model_txn();
        last_ack_count = 0;
        bus_start();
        for (int k = 0; k < tx_q.size(); k++) begin
            send_byte(tx_q[k], acked);
            if (acked) last_ack_count++;
            checks++;
            if (acked !== exp_ack[k]) begin
                errors++;
                $display("[TB] FAIL %s ack byte %0d: got %0b expected %0b", name, k, acked, exp_ack[k]);
            end
        end
        checks++;
        if (obs_wr.size() - base != exp_wr.size()) begin
            errors++;
            $display("[TB] FAIL %s write count: got %0d expected %0d", name, obs_wr.size() - base, exp_wr.size());
        end else begin
            for (int k = 0; k < exp_wr.size(); k++) begin
                checks++;
                if (obs_wr[base + k] !== exp_wr[k]) begin
                    errors++;
                    $display("[TB] FAIL %s write %0d addr/data: got %h expected %h", name, k, obs_wr[base + k], exp_wr[k]);
                end
            end
        end
    endtask

    task automatic check_regs(input string name);
        logic [7:0] expv;
        for (int i = 0; i < NUM_REG + 8; i++) begin
            dbg_addr = 8'(i);
            #1;
            expv = (i < NUM_REG) ? model_regs[i] : 8'h00;
            checks++;
            if (dbg_data !== expv) begin
                errors++;
                $display("[TB] FAIL %s dbg_data[%0d]: got %h expected %h", name, i, dbg_data, expv);
            end
        end
    endtask

    task automatic check_dbg(input string name, input logic [7:0] a, input logic [7:0] expv);
        dbg_addr = a;
        #1;
        checks++;
        if (dbg_data !== expv) begin
            errors++;
            $display("[TB] FAIL %s dbg_data[%0d]: got %h expected %h", name, a, dbg_data, expv);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        dbg_addr = 8'h00;
        for (int i = 0; i < NUM_REG; i++) model_regs[i] = RESET_VAL;
        model_ptr = 0;
        repeat (4) @(posedge clk_sda);
        #1;
        checks++;
        if ({bus.sda_oe, wr_en, busy, stop_det, wr_addr, wr_data} !== 20'h0) begin
            errors++;
            $display("[TB] FAIL reset outputs: got oe=%0b wr_en=%0b busy=%0b stop=%0b addr=%h data=%h expected all zero",
                     bus.sda_oe, wr_en, busy, stop_det, wr_addr, wr_data);
        end
        rst_n = 1'b1;
        repeat (4) @(posedge clk_sda);
        check_regs("reset");
    endtask

    task automatic test_burst();
        int base_stop;
        int base_wr;
        base_stop = stop_count;
        base_wr = obs_wr.size();
        tx_q = '{8'h14, 8'h12, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF,
                 8'hAB, 8'hAC, 8'hAD, 8'hAE, 8'hAF};
        run_txn("burst");
        checks++;
        if (last_ack_count != 13) begin
            errors++;
            $display("[TB] FAIL burst ack count: got %0d expected 13", last_ack_count);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL burst busy mid-transfer: got %0b expected 1", busy);
        end
        bus_stop();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL burst busy after stop: got %0b expected 0", busy);
        end
        checks++;
        if (stop_count - base_stop != 1) begin
            errors++;
            $display("[TB] FAIL burst stop_det pulses: got %0d expected 1", stop_count - base_stop);
        end
        checks++;
        if (obs_wr.size() - base_wr != 11 || obs_wr[base_wr][15:8] !== 8'd18 || obs_wr[obs_wr.size()-1][15:8] !== 8'd28) begin
            errors++;
            $display("[TB] FAIL burst write span: got %0d writes expected 11 covering addrs 18..28", obs_wr.size() - base_wr);
        end
        check_dbg("burst", 8'd18, 8'hAA);
        check_dbg("burst", 8'd28, 8'hAF);
        check_regs("burst");
    endtask

    task automatic test_read();
        logic       acked;
        logic [7:0] v;
        int         base;
        base = obs_wr.size();
        tx_q = '{8'h14, 8'h14};
        run_txn("read_setup");
        bus_start();
        send_byte(8'h15, acked);
`ifdef I2C_READ_EN
        checks++;
        if (acked !== 1'b1) begin
            errors++;
            $display("[TB] FAIL read addr ack: got %0b expected 1", acked);
        end
        recv_byte(1'b1, v);
        checks++;
        if (v !== model_regs[20]) begin
            errors++;
            $display("[TB] FAIL read byte0: got %h expected %h", v, model_regs[20]);
        end
        recv_byte(1'b0, v);
        checks++;
        if (v !== model_regs[21]) begin
            errors++;
            $display("[TB] FAIL read byte1: got %h expected %h", v, model_regs[21]);
        end
        send_byte(8'h55, acked);
        checks++;
        if (acked !== 1'b0) begin
            errors++;
            $display("[TB] FAIL read ignore after nack: got ack %0b expected 0", acked);
        end
`else
        checks++;
        if (acked !== 1'b0) begin
            errors++;
            $display("[TB] FAIL read addr nack: got ack %0b expected 0", acked);
        end
`endif
        bus_stop();
        checks++;
        if (obs_wr.size() != base) begin
            errors++;
            $display("[TB] FAIL read writes: got %0d expected 0", obs_wr.size() - base);
        end
    endtask

    task automatic test_wrong_addr();
        tx_q = '{8'h16, 8'h12, 8'h99};
        run_txn("wrong_addr");
        bus_stop();
        check_regs("wrong_addr");
    endtask

    task automatic test_bad_reg();
        tx_q = '{8'h14, 8'h28, 8'h55, 8'h66};
        run_txn("bad_reg");
        bus_stop();
        check_regs("bad_reg");
    endtask

    task automatic test_wrap();
        tx_q = '{8'h14, 8'h1F, 8'h11, 8'h22};
        run_txn("wrap");
        bus_stop();
        check_dbg("wrap", 8'd31, 8'h11);
        check_dbg("wrap", 8'd0, 8'h22);
    endtask

    task automatic test_back_to_back();
        int base_stop;
        base_stop = stop_count;
        tx_q = '{8'h14, 8'h05, 8'hA1};
        run_txn("b2b_first");
        tx_q = '{8'h14, 8'h07, 8'hB2, 8'hB3};
        run_txn("b2b_second");
        bus_stop();
        checks++;
        if (stop_count - base_stop != 1) begin
            errors++;
            $display("[TB] FAIL b2b stop_det pulses: got %0d expected 1", stop_count - base_stop);
        end
        check_regs("b2b");
    endtask

    task automatic test_random();
        int   n;
        int   r;
        logic [7:0] a;
        for (int t = 0; t < 12; t++) begin
            r = int'($urandom_range(0, 9));
            a = (r < 7) ? 8'h14 : 8'($urandom_range(0, 255));
            if (a == 8'h15) a = 8'h17;
            tx_q.delete();
            tx_q.push_back(a);
            tx_q.push_back(8'($urandom_range(0, 39)));
            n = int'($urandom_range(0, 4));
            for (int k = 0; k < n; k++) tx_q.push_back(8'($urandom));
            run_txn("random");
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL random busy mid-transfer: got %0b expected 1", busy);
            end
            if ($urandom_range(0, 1) == 1) bus_stop();
        end
        bus_stop();
        check_regs("random");
    endtask

    task automatic test_reset_mid();
        logic acked;
        // Reset while the target is actively pulling SDA for an ACK.
        bus_start();
        for (int i = 7; i >= 0; i--) send_bit(tx_q.size() >= 0 ? 8'h14 >> i : 1'b0);
        checks++;
        if (bus.sda_oe !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_mid ack drive: got oe=%0b expected 1", bus.sda_oe);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.sda_oe !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid release: got oe=%0b busy=%0b expected 0 0", bus.sda_oe, busy);
        end
        master_sda = 1'b1; #(Q);
        master_scl = 1'b1; #(Q);
        rst_n = 1'b1; #(Q);
        for (int i = 0; i < NUM_REG; i++) model_regs[i] = RESET_VAL;
        model_ptr = 0;
        // Full byte to reg 18, then a 4-bit partial byte, then reset.
        tx_q = '{8'h14, 8'h12, 8'h77};
        run_txn("reset_mid");
        check_dbg("reset_mid_pre", 8'd18, 8'h77);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.sda_oe !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid partial: got oe=%0b busy=%0b expected 0 0", bus.sda_oe, busy);
        end
        for (int i = 0; i < NUM_REG; i++) model_regs[i] = RESET_VAL;
        model_ptr = 0;
        check_dbg("reset_mid_post", 8'd18, RESET_VAL);
        master_sda = 1'b1; #(Q);
        master_scl = 1'b1; #(Q);
        rst_n = 1'b1; #(Q);
        check_regs("reset_mid");
        acked = 1'b0;
    endtask

    initial begin
        $display("[TB] starting i2c_slave_regfile bench");
        test_reset();
        test_burst();
        test_read();
        test_wrong_addr();
        test_bad_reg();
        test_wrap();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
